sq_period_meter: RTL and testbench

- Sits directly downstream of the threshold/square-wave stage and consumes its registered 1-bit `sigout`.
- Measures the period and high time of that square wave in clk cycles, then emits one valid pulse per completed period.
- Signals a timeout when no rising edge arrives within a programmable window.
- Its results feed the sorting controller's frequency/duty decision logic.

---
 rtl/sq_meas_pkg.sv | 18 +
 rtl/sq_glitch_filter.sv | 38 +++
 rtl/sq_period_meter.sv | 126 ++++++++++++
 tb/tb_sq_period_meter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sq_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sq_meas_pkg
//  Purpose  : Shared state encoding and default sizing for the period meter.
//  Revision : 1.0
// ============================================================================
package sq_meas_pkg;

    localparam int DEF_CNT_W          = 24;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage : sq_meas_pkg
`default_nettype wire

// File: rtl/sq_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module   : sq_glitch_filter
//  Purpose  : Output level follows d only after d has held a new value for
//             FILT_LEN consecutive cycles; shorter pulses are swallowed.
//  Revision : 1.0
// ============================================================================
module sq_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int            RUN_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);

    logic [RUN_W-1:0] run;

    // run counts consecutive samples disagreeing with q; any agreement restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 1'b0;
            run <= '0;
        end else if (d == q) begin
            run <= '0;
        end else if (run == RUN_LAST) begin
            q   <= d;
            run <= '0;
        end else begin
            run <= run + RUN_W'(1);
        end
    end

endmodule : sq_glitch_filter
`default_nettype wire

// File: rtl/sq_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : sq_period_meter
//  Purpose  : Measures period and high time of a synchronous square wave,
//             pulses meas_valid per completed period, flags a missing signal.
//             Optional input deglitching when GLITCH_FILTER_EN is defined.
//  Revision : 1.0
// ============================================================================
module sq_period_meter
    import sq_meas_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILT_LEN       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sq_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout,
    output logic             no_signal
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic level;

`ifdef GLITCH_FILTER_EN
    sq_glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_glitch_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sq_in),
        .q     (level)
    );
`else
    logic unused_filt_len;
    assign unused_filt_len = (FILT_LEN > 0);
    assign level           = sq_in;
`endif

    state_t           state;
    logic             s0;
    logic             s1;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] hi_hold;

    assign rise = s0 & ~s1;
    assign fall = ~s0 & s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s0         <= 1'b0;
            s1         <= 1'b0;
            cnt        <= '0;
            hi_cnt     <= '0;
            hi_hold    <= '0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            timeout    <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            s0         <= level;
            s1         <= s0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    // first rise only opens a window; the period before it is partial
                    if (rise) begin
                        state  <= MEASURE;
                        hi_cnt <= CNT_ONE;
                    end
                end

                MEASURE: begin
                    cnt <= cnt + CNT_ONE;
                    if (s0 && (hi_cnt != CNT_MAX)) begin
                        hi_cnt <= hi_cnt + CNT_ONE;
                    end
                    if (fall) begin
                        hi_hold <= hi_cnt;
                    end

                    // a rise on the last window cycle closes the period instead of timing out
                    if (rise) begin
                        period     <= cnt + CNT_ONE;
                        high_time  <= hi_hold;
                        meas_valid <= 1'b1;
                        no_signal  <= 1'b0;
                        cnt        <= '0;
                        hi_cnt     <= CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        timeout   <= 1'b1;
                        no_signal <= 1'b1;
                        period    <= '0;
                        high_time <= '0;
                        cnt       <= '0;
                        hi_cnt    <= '0;
                        hi_hold   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : sq_period_meter
`default_nettype wire

// File: tb/tb_sq_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sq_period_meter
//  Purpose  : Directed self-checking bench with a measurement scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_sq_period_meter;

    localparam int CW = 16;
    localparam int TO = 50;
    localparam int FL = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          sq_in = 1'b0;
    logic          meas_valid;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          timeout;
    logic          no_signal;

    sq_period_meter #(
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TO),
        .FILT_LEN       (FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sq_in      (sq_in),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .timeout    (timeout),
        .no_signal  (no_signal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] p;
        logic [CW-1:0] h;
    } meas_t;

    meas_t exp_q[$];
    meas_t prev;
    bit    have_prev      = 1'b0;
    bit    to_expected    = 1'b0;
    int    cyc            = 0;
    int    last_valid_cyc = 0;
    int    n_checks       = 0;
    int    n_fail         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // scoreboard consumer: every meas_valid must match the oldest expected period
    always @(negedge clk) begin
        meas_t m;
        if (meas_valid === 1'b1) begin
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                m = exp_q.pop_front();
                check("period", 32'(period), 32'(m.p));
                check("high_time", 32'(high_time), 32'(m.h));
            end
        end
        if (timeout === 1'b1 && !to_expected) begin
            check("unexpected_timeout", 32'd1, 32'd0);
        end
    end

    // one full period: high for h samples then low; completes the previous period's expectation
    task automatic wave(input int p, input int h, input bit glitch);
        logic v;
        if (have_prev) exp_q.push_back(prev);
        prev.p    = p[CW-1:0];
        prev.h    = h[CW-1:0];
        have_prev = 1'b1;
        for (int i = 0; i < p; i++) begin
            @(posedge clk);
            #1;
            v = (i < h);
            if (glitch && (i == 3 || i == 4))   v = 1'b0;
            if (glitch && (i == 13 || i == 14)) v = 1'b1;
            sq_in = v;
        end
    endtask

    task automatic wait_timeout();
        bit found;
        found       = 1'b0;
        to_expected = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) found = 1'b1;
        end
        check("timeout_seen", 32'(found), 32'd1);
        if (found) begin
            check("timeout_latency", 32'(cyc - last_valid_cyc), 32'(TO));
            check("to_period", 32'(period), 32'd0);
            check("to_high_time", 32'(high_time), 32'd0);
            check("to_no_signal", 32'(no_signal), 32'd1);
            @(negedge clk);
            check("timeout_one_cycle", 32'(timeout), 32'd0);
        end
        to_expected = 1'b0;
        have_prev   = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_no_signal", 32'(no_signal), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        repeat (5) wave(10, 4, 1'b0);
        check("no_signal_after_valid", 32'(no_signal), 32'd0);
        repeat (3) wave(10, 7, 1'b0);
        wait_timeout();

        // period equal to the timeout window: rise on the last cycle must win
        repeat (3) wave(TO, 20, 1'b0);
        wait_timeout();

        repeat (2) wave(10, 4, 1'b0);
        exp_q.push_back(prev);
        have_prev = 1'b0;
        @(posedge clk);
        #1 sq_in = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_meas_valid", 32'(meas_valid), 32'd0);
        check("arst_period", 32'(period), 32'd0);
        check("arst_high_time", 32'(high_time), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_no_signal", 32'(no_signal), 32'd1);
        check("arst_queue_consumed", 32'(exp_q.size()), 32'd0);
        sq_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) wave(10, 4, 1'b0);
        wait_timeout();

`ifdef GLITCH_FILTER_EN
        repeat (4) wave(20, 10, 1'b1);
        wait_timeout();
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sq_period_meter
`default_nettype wire
